// File: rtl/nest_checker.sv
// Streaming begin/end (and optionally fork/join) nesting checker over ASCII text.
// Keywords are recognised whole-word, case-insensitive, and committed at the following separator.
module nest_checker #(
  parameter int DEPTH  = 8,
  parameter int MODE   = 1,
  parameter int STICKY = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid,
  input  logic [7:0]                   in,
  output logic                         result,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         error
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  // Keyword index: 0 begin, 1 end, 2 fork, 3 join; characters held MSB-first
  function automatic logic [7:0] kw_char(input logic [1:0] kw, input logic [2:0] pos);
    logic [39:0] word;
    logic [7:0]  ch;
    case (kw)
      2'd0:    word = 40'h626567696E;
      2'd1:    word = {24'h656E64, 16'h0000};
      2'd2:    word = {32'h666F726B, 8'h00};
      2'd3:    word = {32'h6A6F696E, 8'h00};
      default: word = 40'h0000000000;
    endcase
    case (pos)
      3'd0:    ch = word[39:32];
      3'd1:    ch = word[31:24];
      3'd2:    ch = word[23:16];
      3'd3:    ch = word[15:8];
      3'd4:    ch = word[7:0];
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  function automatic logic [2:0] kw_len(input logic [1:0] kw);
    logic [2:0] len;
    case (kw)
      2'd0:    len = 3'd5;
      2'd1:    len = 3'd3;
      2'd2:    len = 3'd4;
      2'd3:    len = 3'd4;
      default: len = 3'd7;
    endcase
    return len;
  endfunction

  logic [DEPTH-1:0] r_stack;
  logic [DW-1:0]    r_depth;
  logic             r_error;
  logic [2:0]       r_len;
  logic [3:0]       r_viable;

  logic             w_is_letter;
  logic [7:0]       w_lower;
  logic [3:0]       w_viable_nxt;
  logic [3:0]       w_match;
  logic             w_open;
  logic             w_close;
  logic             w_type;
  logic             w_top;
  logic             w_err_new;
  logic             w_eff_err;
  logic [DW-1:0]    w_eff_depth;
  logic [DEPTH-1:0] w_eff_stack;

  // Character classification and pending-word viability tracking
  always_comb begin
    w_is_letter  = ((in >= 8'h41) && (in <= 8'h5A)) || ((in >= 8'h61) && (in <= 8'h7A));
    w_lower      = in | 8'h20;
    w_viable_nxt = 4'b0000;
    w_match      = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_viable_nxt[k] = ((r_len == 3'd0) || r_viable[k]) && (r_len < 3'd5) &&
                        (w_lower == kw_char(2'(k), r_len));
      w_match[k]      = r_viable[k] && (r_len == kw_len(2'(k)));
    end
    if (MODE == 0) begin
      w_match[3:2] = 2'b00;
    end else begin
      w_match[3:2] = w_match[3:2];
    end
    w_open  = w_match[0] | w_match[2];
    w_close = w_match[1] | w_match[3];
    w_type  = w_match[2] | w_match[3];
  end

  // Committed state with the pending word applied as if a separator arrived now
  always_comb begin
    w_top       = |(r_stack & (DEPTH'(1) << (r_depth - DW'(1))));
    w_eff_depth = r_depth;
    w_eff_stack = r_stack;
    w_err_new   = 1'b0;
    if (w_open) begin
      if (r_depth == FULL) begin
        w_err_new = 1'b1;
      end else begin
        w_eff_stack = (r_stack & ~(DEPTH'(1) << r_depth)) | (DEPTH'(w_type) << r_depth);
        w_eff_depth = r_depth + DW'(1);
      end
    end else if (w_close) begin
      if (r_depth == DW'(0)) begin
        w_err_new = 1'b1;
      end else if (w_top != w_type) begin
        w_err_new = 1'b1;
      end else begin
        w_eff_depth = r_depth - DW'(1);
      end
    end else begin
      w_err_new = 1'b0;
    end
    // Non-sticky: an old error survives only while nesting is still open
    if (STICKY != 0) begin
      w_eff_err = r_error | w_err_new;
    end else begin
      w_eff_err = w_err_new | (r_error & (w_eff_depth != DW'(0)));
    end
    result = (w_eff_depth == DW'(0)) && !w_eff_err;
  end

  // Letters extend the pending word; separators commit it and clear it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stack  <= '0;
      r_depth  <= DW'(0);
      r_error  <= 1'b0;
      r_len    <= 3'd0;
      r_viable <= 4'b0000;
    end else if (valid) begin
      if (w_is_letter) begin
        r_viable <= w_viable_nxt;
        r_len    <= (r_len == 3'd6) ? r_len : (r_len + 3'd1);
      end else begin
        r_stack  <= w_eff_stack;
        r_depth  <= w_eff_depth;
        r_error  <= w_eff_err;
        r_len    <= 3'd0;
        r_viable <= 4'b0000;
      end
    end
  end

  assign depth = r_depth;
  assign error = r_error;

endmodule

// File: tb/tb_nest_checker.sv
// Directed bench for nest_checker across four parameterisations sharing one stimulus stream.
module tb_nest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] in = 8'h20;

  logic       res_def, err_def, res_d2, err_d2, res_m0, err_m0, res_s0, err_s0;
  logic [3:0] dep_def, dep_m0, dep_s0;
  logic [1:0] dep_d2;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  nest_checker #(.DEPTH(8), .MODE(1), .STICKY(1)) u_def (
    .clk(clk), .reset(reset), .valid(valid), .in(in),
    .result(res_def), .depth(dep_def), .error(err_def));
  nest_checker #(.DEPTH(2), .MODE(1), .STICKY(1)) u_d2 (
    .clk(clk), .reset(reset), .valid(valid), .in(in),
    .result(res_d2), .depth(dep_d2), .error(err_d2));
  nest_checker #(.DEPTH(8), .MODE(0), .STICKY(1)) u_m0 (
    .clk(clk), .reset(reset), .valid(valid), .in(in),
    .result(res_m0), .depth(dep_m0), .error(err_m0));
  nest_checker #(.DEPTH(8), .MODE(1), .STICKY(0)) u_s0 (
    .clk(clk), .reset(reset), .valid(valid), .in(in),
    .result(res_s0), .depth(dep_s0), .error(err_s0));

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    valid = 1'b1;
    in    = c;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0;
      in    = 8'h65;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++; if (res_def !== 1'b1) begin n_miss++; $display("FAIL reset_result got %b want 1", res_def); end
    n_vec++; if (dep_def !== 4'd0) begin n_miss++; $display("FAIL reset_depth got %0d want 0", dep_def); end
    n_vec++; if (err_def !== 1'b0) begin n_miss++; $display("FAIL reset_error got %b want 0", err_def); end
    n_vec++; if ({res_d2, res_m0, res_s0} !== 3'b111) begin n_miss++; $display("FAIL reset_result_all got %b want 111", {res_d2, res_m0, res_s0}); end
  endtask

  task automatic test_begin_end;
    do_reset();
    send_str("begi");
    n_vec++; if (res_def !== 1'b1) begin n_miss++; $display("FAIL be_after_i got %b want 1", res_def); end
    send("n");
    n_vec++; if (res_def !== 1'b0) begin n_miss++; $display("FAIL be_after_n got %b want 0", res_def); end
    n_vec++; if (dep_def !== 4'd0) begin n_miss++; $display("FAIL be_depth_pending got %0d want 0", dep_def); end
    send(" ");
    n_vec++; if (dep_def !== 4'd1) begin n_miss++; $display("FAIL be_depth_open got %0d want 1", dep_def); end
    send_str("end");
    n_vec++; if (res_def !== 1'b1) begin n_miss++; $display("FAIL be_after_d got %b want 1", res_def); end
    n_vec++; if (dep_def !== 4'd1) begin n_miss++; $display("FAIL be_depth_before_sep got %0d want 1", dep_def); end
    send(" ");
    n_vec++; if ({dep_def, err_def, res_def} !== {4'd0, 1'b0, 1'b1}) begin n_miss++; $display("FAIL be_final got d%0d e%b r%b want d0 e0 r1", dep_def, err_def, res_def); end
  endtask

  task automatic test_mismatch;
    do_reset();
    send_str("begin fork end");
    n_vec++; if (err_def !== 1'b0) begin n_miss++; $display("FAIL mm_err_before_sep got %b want 0", err_def); end
    send(" ");
    n_vec++; if ({dep_def, err_def, res_def} !== {4'd2, 1'b1, 1'b0}) begin n_miss++; $display("FAIL mm_commit got d%0d e%b r%b want d2 e1 r0", dep_def, err_def, res_def); end
    send_str("join end ");
    n_vec++; if ({err_def, res_def} !== 2'b10) begin n_miss++; $display("FAIL mm_no_recover got e%b r%b want e1 r0", err_def, res_def); end
  endtask

  task automatic test_underflow;
    do_reset();
    send_str("end ");
    n_vec++; if ({dep_def, err_def, res_def} !== {4'd0, 1'b1, 1'b0}) begin n_miss++; $display("FAIL uf_commit got d%0d e%b r%b want d0 e1 r0", dep_def, err_def, res_def); end
    send_str("begin end ");
    n_vec++; if ({err_def, res_def} !== 2'b10) begin n_miss++; $display("FAIL uf_sticky got e%b r%b want e1 r0", err_def, res_def); end
  endtask

  task automatic test_overflow_mode0;
    do_reset();
    send_str("begin begin ");
    n_vec++; if ({dep_d2, err_d2} !== {2'd2, 1'b0}) begin n_miss++; $display("FAIL of_full got d%0d e%b want d2 e0", dep_d2, err_d2); end
    send_str("begin ");
    n_vec++; if ({dep_d2, err_d2} !== {2'd2, 1'b1}) begin n_miss++; $display("FAIL of_overflow got d%0d e%b want d2 e1", dep_d2, err_d2); end
    do_reset();
    send_str("fork ");
    n_vec++; if ({dep_m0, res_m0} !== {4'd0, 1'b1}) begin n_miss++; $display("FAIL m0_fork got d%0d r%b want d0 r1", dep_m0, res_m0); end
    n_vec++; if (dep_def !== 4'd1) begin n_miss++; $display("FAIL m1_fork got d%0d want 1", dep_def); end
    send_str("join ");
    n_vec++; if ({dep_m0, res_m0, err_m0} !== {4'd0, 1'b1, 1'b0}) begin n_miss++; $display("FAIL m0_join got d%0d r%b e%b want d0 r1 e0", dep_m0, res_m0, err_m0); end
  endtask

  task automatic test_case_word;
    do_reset();
    send_str("BEGIN ");
    n_vec++; if (dep_def !== 4'd1) begin n_miss++; $display("FAIL cw_upper_begin got %0d want 1", dep_def); end
    send_str("en");
    idle(2);
    n_vec++; if ({dep_def, res_def} !== {4'd1, 1'b0}) begin n_miss++; $display("FAIL cw_gap got d%0d r%b want d1 r0", dep_def, res_def); end
    send("d");
    n_vec++; if (res_def !== 1'b1) begin n_miss++; $display("FAIL cw_after_d got %b want 1", res_def); end
    idle(3);
    n_vec++; if ({dep_def, res_def} !== {4'd1, 1'b1}) begin n_miss++; $display("FAIL cw_gap_hold got d%0d r%b want d1 r1", dep_def, res_def); end
    send("x");
    n_vec++; if (res_def !== 1'b0) begin n_miss++; $display("FAIL cw_after_x got %b want 0", res_def); end
    send(" ");
    n_vec++; if (dep_def !== 4'd1) begin n_miss++; $display("FAIL cw_endx_ignored got %0d want 1", dep_def); end
    send_str("xend ends end");
    n_vec++; if ({dep_def, res_def} !== {4'd1, 1'b1}) begin n_miss++; $display("FAIL cw_final_d got d%0d r%b want d1 r1", dep_def, res_def); end
    send(" ");
    n_vec++; if ({dep_def, res_def, err_def} !== {4'd0, 1'b1, 1'b0}) begin n_miss++; $display("FAIL cw_close got d%0d r%b e%b want d0 r1 e0", dep_def, res_def, err_def); end
  endtask

  task automatic test_nonsticky;
    do_reset();
    send_str("end ");
    n_vec++; if (err_s0 !== 1'b1) begin n_miss++; $display("FAIL ns_err_set got %b want 1", err_s0); end
    send(" ");
    n_vec++; if (err_s0 !== 1'b0) begin n_miss++; $display("FAIL ns_err_clear got %b want 0", err_s0); end
    n_vec++; if (err_def !== 1'b1) begin n_miss++; $display("FAIL st_err_held got %b want 1", err_def); end
    send_str("begin end ");
    n_vec++; if ({dep_s0, err_s0, res_s0} !== {4'd0, 1'b0, 1'b1}) begin n_miss++; $display("FAIL ns_end got d%0d e%b r%b want d0 e0 r1", dep_s0, err_s0, res_s0); end
    send_str("begin beg");
    // Reset wins over a simultaneously valid byte and discards the partial word
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b1;
    in    = 8'h69;
    @(posedge clk);
    #1;
    reset = 1'b0;
    valid = 1'b0;
    n_vec++; if ({dep_s0, res_s0, err_s0} !== {4'd0, 1'b1, 1'b0}) begin n_miss++; $display("FAIL ns_mid_reset got d%0d r%b e%b want d0 r1 e0", dep_s0, res_s0, err_s0); end
    send_str("in ");
    n_vec++; if ({dep_s0, res_s0} !== {4'd0, 1'b1}) begin n_miss++; $display("FAIL ns_partial_dropped got d%0d r%b want d0 r1", dep_s0, res_s0); end
  endtask

  initial begin
    test_reset();
    test_begin_end();
    test_mismatch();
    test_underflow();
    test_overflow_mode0();
    test_case_word();
    test_nonsticky();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
